// File: rtl/fc_stream_accel.sv
// Streaming fully-connected layer: loads an int8 input vector, then for each group
// of LANES neurons loads the bias, accumulates int8 dot products, requantizes and stores.
module fc_stream_accel #(
    parameter int ADDR_WIDTH = 32,
    parameter int LANES      = 4,
    parameter int MAX_IN     = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    input  logic [ADDR_WIDTH-1:0] in_base,
    input  logic [ADDR_WIDTH-1:0] w_base,
    input  logic [ADDR_WIDTH-1:0] b_base,
    input  logic [ADDR_WIDTH-1:0] out_base,
    input  logic [15:0]           input_size,
    input  logic [15:0]           output_size,
    input  logic [7:0]            in_zp,
    input  logic [7:0]            out_zp,
    input  logic [4:0]            out_shift,
    input  logic                  relu_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_re,
    output logic                  mem_we,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_ready
);

    localparam int WORDS = MAX_IN / 4;
    localparam int IW    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_LOAD_IN, S_LOAD_BIAS, S_COMPUTE, S_STORE, S_FINISH
    } state_t;

    state_t                state_q, state_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic [ADDR_WIDTH-1:0] in_base_q, in_base_d;
    logic [ADDR_WIDTH-1:0] w_base_q, w_base_d;
    logic [ADDR_WIDTH-1:0] b_base_q, b_base_d;
    logic [ADDR_WIDTH-1:0] out_base_q, out_base_d;
    logic [15:0]           in_size_q, in_size_d;
    logic [15:0]           out_size_q, out_size_d;
    logic [7:0]            in_zp_q, in_zp_d;
    logic [7:0]            out_zp_q, out_zp_d;
    logic [4:0]            shift_q, shift_d;
    logic                  relu_q, relu_d;
    logic [15:0]           k_q, k_d;
    logic [LW-1:0]         lane_q, lane_d;
    logic [16:0]           o_q, o_d;
    logic [31:0]           acc_q [LANES];
    logic [31:0]           acc_d [LANES];
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                  mem_re_q, mem_re_d;
    logic                  mem_we_q, mem_we_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d;

    logic [31:0]           in_buf [WORDS];
    logic [31:0]           x_word_q;
    logic                  buf_we;

    logic                  accept;
    logic                  last_word;
    logic                  last_lane;
    logic                  last_group;
    logic [16:0]           neuron;
    logic [16:0]           next_neuron;
    logic [32:0]           w_row_off;

    // Sum over the 4 packed bytes of (x - zp) * w; 17-bit products, 32-bit wrapping sum.
    function automatic logic [31:0] dot4(input logic [31:0] xw, input logic [31:0] ww,
                                         input logic [7:0] zp);
        logic signed [8:0]  xd;
        logic signed [16:0] xe;
        logic signed [16:0] we;
        logic signed [16:0] p;
        logic [31:0]        s;
        s = '0;
        for (int b = 0; b < 4; b++) begin
            xd = $signed({xw[8*b+7], xw[8*b +: 8]}) - $signed({zp[7], zp});
            xe = 17'(xd);
            we = 17'($signed(ww[8*b +: 8]));
            p  = xe * we;
            s  = s + 32'(p);
        end
        return s;
    endfunction

    // Rounding arithmetic shift, output zero point, optional ReLU at the zero point, int8 clamp.
    function automatic logic [31:0] requant(input logic [31:0] acc, input logic [4:0] sh,
                                            input logic [7:0] zp, input logic relu);
        logic signed [32:0] a;
        logic signed [32:0] r;
        logic signed [33:0] zpe;
        logic signed [33:0] y;
        a = $signed({acc[31], acc});
        if (sh == 5'd0) begin
            r = a;
        end else begin
            r = (a + (33'sd1 <<< (sh - 5'd1))) >>> sh;
        end
        zpe = 34'($signed(zp));
        y   = 34'(r) + zpe;
        if (relu && (y < zpe)) begin
            y = zpe;
        end
        if (y > 34'sd127) begin
            y = 34'sd127;
        end else if (y < -34'sd128) begin
            y = -34'sd128;
        end
        return 32'(y);
    endfunction

    assign accept     = (mem_re_q | mem_we_q) & mem_ready;
    assign last_word  = (k_q == ((in_size_q >> 2) - 16'd1));
    assign neuron     = o_q + 17'(lane_q);
    assign last_lane  = (lane_q == LW'(LANES - 1)) || ((neuron + 17'd1) >= {1'b0, out_size_q});
    assign last_group = (o_q + 17'(LANES)) >= {1'b0, out_size_q};

    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = err_q;
        in_base_d  = in_base_q;
        w_base_d   = w_base_q;
        b_base_d   = b_base_q;
        out_base_d = out_base_q;
        in_size_d  = in_size_q;
        out_size_d = out_size_q;
        in_zp_d    = in_zp_q;
        out_zp_d   = out_zp_q;
        shift_d    = shift_q;
        relu_d     = relu_q;
        k_d        = k_q;
        lane_d     = lane_q;
        o_d        = o_q;
        buf_we     = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            acc_d[i] = acc_q[i];
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    in_base_d  = in_base;
                    w_base_d   = w_base;
                    b_base_d   = b_base;
                    out_base_d = out_base;
                    in_size_d  = input_size;
                    out_size_d = output_size;
                    in_zp_d    = in_zp;
                    out_zp_d   = out_zp;
                    shift_d    = out_shift;
                    relu_d     = relu_en;
                    err_d      = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = S_CHECK;
                end
            end
            S_CHECK: begin
                if ((in_size_q == 16'd0) || (out_size_q == 16'd0) ||
                    ({16'd0, in_size_q} > 32'(MAX_IN)) || (in_size_q[1:0] != 2'd0)) begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_FINISH;
                end else begin
                    k_d     = '0;
                    state_d = S_LOAD_IN;
                end
            end
            S_LOAD_IN: begin
                if (accept) begin
                    buf_we = 1'b1;
                    if (last_word) begin
                        k_d     = '0;
                        lane_d  = '0;
                        o_d     = '0;
                        state_d = S_LOAD_BIAS;
                    end else begin
                        k_d = k_q + 16'd1;
                    end
                end
            end
            S_LOAD_BIAS: begin
                if (accept) begin
                    acc_d[lane_q] = mem_rdata;
                    if (last_lane) begin
                        lane_d  = '0;
                        state_d = S_COMPUTE;
                    end else begin
                        lane_d = lane_q + LW'(1);
                    end
                end
            end
            S_COMPUTE: begin
                if (accept) begin
                    acc_d[lane_q] = acc_q[lane_q] + dot4(x_word_q, mem_rdata, in_zp_q);
                    if (last_lane) begin
                        lane_d = '0;
                        if (last_word) begin
                            k_d     = '0;
                            state_d = S_STORE;
                        end else begin
                            k_d = k_q + 16'd1;
                        end
                    end else begin
                        lane_d = lane_q + LW'(1);
                    end
                end
            end
            S_STORE: begin
                if (accept) begin
                    if (last_lane) begin
                        lane_d = '0;
                        if (last_group) begin
                            done_d  = 1'b1;
                            state_d = S_FINISH;
                        end else begin
                            o_d     = o_q + 17'(LANES);
                            state_d = S_LOAD_BIAS;
                        end
                    end else begin
                        lane_d = lane_q + LW'(1);
                    end
                end
            end
            S_FINISH: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The next request is derived from the next-cycle position, so a stalled
        // request naturally holds its address and data.
        next_neuron = o_d + 17'(lane_d);
        w_row_off   = 33'(next_neuron) * 33'(in_size_q);
        mem_re_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        case (state_d)
            S_LOAD_IN: begin
                mem_re_d   = 1'b1;
                mem_addr_d = in_base_q + ADDR_WIDTH'({k_d, 2'b00});
            end
            S_LOAD_BIAS: begin
                mem_re_d   = 1'b1;
                mem_addr_d = b_base_q + ADDR_WIDTH'({next_neuron, 2'b00});
            end
            S_COMPUTE: begin
                mem_re_d   = 1'b1;
                mem_addr_d = w_base_q + ADDR_WIDTH'(w_row_off) + ADDR_WIDTH'({k_d, 2'b00});
            end
            S_STORE: begin
                mem_we_d    = 1'b1;
                mem_addr_d  = out_base_q + ADDR_WIDTH'({next_neuron, 2'b00});
                mem_wdata_d = requant(acc_d[lane_d], shift_q, out_zp_q, relu_q);
            end
            default: begin
                mem_re_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            in_base_q   <= '0;
            w_base_q    <= '0;
            b_base_q    <= '0;
            out_base_q  <= '0;
            in_size_q   <= '0;
            out_size_q  <= '0;
            in_zp_q     <= '0;
            out_zp_q    <= '0;
            shift_q     <= '0;
            relu_q      <= 1'b0;
            k_q         <= '0;
            lane_q      <= '0;
            o_q         <= '0;
            mem_addr_q  <= '0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            for (int i = 0; i < LANES; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            in_base_q   <= in_base_d;
            w_base_q    <= w_base_d;
            b_base_q    <= b_base_d;
            out_base_q  <= out_base_d;
            in_size_q   <= in_size_d;
            out_size_q  <= out_size_d;
            in_zp_q     <= in_zp_d;
            out_zp_q    <= out_zp_d;
            shift_q     <= shift_d;
            relu_q      <= relu_d;
            k_q         <= k_d;
            lane_q      <= lane_d;
            o_q         <= o_d;
            mem_addr_q  <= mem_addr_d;
            mem_re_q    <= mem_re_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            for (int i = 0; i < LANES; i++) begin
                acc_q[i] <= acc_d[i];
            end
        end
    end

    // Input buffer RAM; the read address is the next word index so x_word_q tracks k_q.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            in_buf[k_q[IW-1:0]] <= mem_rdata;
        end
        x_word_q <= in_buf[k_d[IW-1:0]];
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign mem_addr  = mem_addr_q;
    assign mem_re    = mem_re_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;

endmodule
